tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Command-driven sequencer that sweeps `tile_processor` over a grid of up to 8×8 tiles. It accepts one operation command (op code plus grid size) from the host or control register block. It then drives `tile_processor`'s `start`/`tile_i`/`tile_j`/`op_code` in raster order and waits for each tile's completion. Busy, progress and error status are reported back. It sits between the host control path and the `tile_processor` instance, which it owns exclusively.

## Interface
Parameters:
- `TILE_W`, 3: width of tile index and grid-size fields.
- `TIMEOUT_CYCLES`, 1024: watchdog limit per tile, in clocks (used only with `TILE_SCHED_TIMEOUT_EN`).

Ports:
- `clk`, in, 1: single clock for the block.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: block can accept a command; high only in IDLE.
- `cmd_op`, in, 3: op code (1 ADD, 2 SUB, 3 CONV, 4 DOT).
- `cmd_rows_m1`, in, `TILE_W`: tile rows minus one.
- `cmd_cols_m1`, in, `TILE_W`: tile columns minus one.
- `abort`, in, 1: cancel the active command.
- `tp_start`, out, 1: one-cycle start pulse to `tile_processor`.
- `tp_tile_i`, out, `TILE_W`: tile row index.
- `tp_tile_j`, out, `TILE_W`: tile column index.
- `tp_op_code`, out, 3: latched op code.
- `tp_done`, in, 1: `tile_processor` done, a level signal.
- `busy`, out, 1: command in progress.
- `sched_done`, out, 1: one-cycle pulse when all tiles complete.
- `tiles_done`, out, 2*`TILE_W`+1: count of tiles completed for the current command.
- `err_op`, out, 1: one-cycle pulse when an illegal op is rejected.
- `err_timeout`, out, 1: sticky watchdog error.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FINISH.
- Reset values:
  - State is IDLE and `cmd_ready`=1.
  - All other outputs are 0, including indices, `tp_op_code`, `tiles_done` and the error flags.
- IDLE:
  - Handshake is `cmd_valid && cmd_ready`.
  - A legal op (1–4) latches op, rows and cols, clears `tiles_done` and `err_timeout`, sets i=j=0 and goes to ISSUE.
  - An illegal op (0, 5–7) pulses `err_op` for one cycle and stays in IDLE. No `tp_start` is issued and nothing is latched.
- DOT (op 4) forces a grid of 1×1 regardless of `cmd_rows_m1`/`cmd_cols_m1`.
- ISSUE:
  - `tp_start`=1 for exactly this cycle, with indices and op stable.
  - Always goes to WAIT.
- WAIT:
  - `tp_done` is registered into `done_q`.
  - Completion is the rising edge `tp_done && !done_q`. This makes a `done` level held over from the previous tile harmless.
  - `done_q` is cleared on entry to ISSUE.
  - On completion, `tiles_done` increments and the state goes to NEXT.
- NEXT:
  - If j < cols_m1: j++ and go to ISSUE.
  - Else if i < rows_m1: j=0, i++ and go to ISSUE.
  - Else go to FINISH.
- FINISH:
  - Pulse `sched_done` for one cycle and go to IDLE.
  - Indices, op and `tiles_done` hold their final values until the next accepted command.
- `busy` = (state != IDLE).
- `abort`:
  - In any non-IDLE state, go to IDLE on the next edge.
  - No `sched_done`; `tp_start` is forced low that cycle.
  - `tiles_done` holds.
  - Abort is ignored in IDLE.
- Simultaneous events: abort and a completion edge in the same cycle resolves as abort, with `tiles_done` not incremented.
- Reset mid-command: returns immediately to reset values; no pulses are emitted.

## Timing
- Command accepted at edge N gives `tp_start` high during cycle N+1.
- Completion edge detected at edge M:
  - NEXT is at M+1.
  - Next `tp_start` is at M+2, or `sched_done` at M+2 for the last tile.
- Fixed overhead is 3 cycles per tile (ISSUE, edge detect, NEXT) beyond `tile_processor` latency.
- `cmd_ready` returns high the cycle after the `sched_done` pulse.
- `tiles_done` maximum is 64 (7 bits for `TILE_W`=3); rows/cols wrap is impossible because they are bounded by `*_m1`.

## Configuration
- `TILE_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT and is reset on entry to WAIT.
  - If `TIMEOUT_CYCLES` clocks elapse without a completion edge, set `err_timeout` (sticky), go to IDLE and emit no `sched_done`.
- Undefined:
  - No counter logic; `err_timeout` is tied to 0.
  - WAIT waits indefinitely.

## Test plan
- Reset, then op=1, rows_m1=1, cols_m1=1, with a `tp_done` model responding after 20 cycles. Required:
  - 4 `tp_start` pulses with (i,j) = (0,0),(0,1),(1,0),(1,1).
  - `tiles_done`=4, one `sched_done` pulse, `busy` low afterwards.
- op=4 with rows_m1=7, cols_m1=7: exactly 1 `tp_start` at (0,0) and `tiles_done`=1.
- op=0, then op=6: one `err_op` pulse each, `busy` stays 0, no `tp_start`, `cmd_ready` stays 1.
- `tp_done` held high from the previous command when a new command starts. Required:
  - No premature advance.
  - The first tile completes only on the next rising edge of `tp_done`.
- `abort` asserted in WAIT of tile 3 (with `TILE_SCHED_TIMEOUT_EN`), and separately `tp_done` never rising. Required:
  - Abort: IDLE next cycle, `tiles_done`=2, no `sched_done`.
  - Stalled `tp_done`: `err_timeout`=1 after 1024 cycles, cleared by the next accepted command.
- Assert `rst` in the middle of the ISSUE cycle: all outputs return to reset values asynchronously; `tp_start` drops within the same cycle.

Source files
------------

// File: rtl/tile_scheduler.sv
// tile_scheduler: raster-order sequencer that drives one tile_processor over a grid of up to 8x8 tiles.
// Define TILE_SCHED_TIMEOUT_EN to enable the per-tile watchdog (sets sticky err_timeout).
module tile_scheduler #(
  parameter int unsigned TILE_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [TILE_W-1:0]   cmd_rows_m1,
  input  logic [TILE_W-1:0]   cmd_cols_m1,
  input  logic                abort,
  output logic                tp_start,
  output logic [TILE_W-1:0]   tp_tile_i,
  output logic [TILE_W-1:0]   tp_tile_j,
  output logic [2:0]          tp_op_code,
  input  logic                tp_done,
  output logic                busy,
  output logic                sched_done,
  output logic [2*TILE_W:0]   tiles_done,
  output logic                err_op,
  output logic                err_timeout
);

  localparam logic [2:0] OP_DOT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [TILE_W-1:0]   rows_q, cols_q, i_q, j_q;
  logic [2*TILE_W:0]   count_q;
  logic                done_q;
  logic                err_op_q;
  logic                accept, op_legal, complete, timeout;

  assign accept   = (state == S_IDLE) && cmd_valid;
  assign op_legal = (cmd_op >= 3'd1) && (cmd_op <= 3'd4);
  assign complete = (state == S_WAIT) && tp_done && !done_q;

`ifdef TILE_SCHED_TIMEOUT_EN
  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;
  logic             err_timeout_q;

  assign timeout     = (state == S_WAIT) && !complete && (timer_q == TMR_LAST);
  assign err_timeout = err_timeout_q;

  // Timer sits at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state == S_WAIT) timer_q <= timer_q + TMR_W'(1);
      else                 timer_q <= '0;
      if (accept && op_legal)  err_timeout_q <= 1'b0;
      else if (timeout && !abort) err_timeout_q <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if ((state != S_IDLE) && abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (accept && op_legal) state_nxt = S_ISSUE;
        S_ISSUE:  state_nxt = S_WAIT;
        S_WAIT: begin
          if (complete)     state_nxt = S_NEXT;
          else if (timeout) state_nxt = S_IDLE;
        end
        S_NEXT:   state_nxt = ((j_q < cols_q) || (i_q < rows_q)) ? S_ISSUE : S_FINISH;
        S_FINISH: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // done_q follows tp_done every cycle except the edge into ISSUE, so a level
  // still high from the previous tile is captured during ISSUE and never looks like a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_op_q <= 1'b0;
    end else begin
      err_op_q <= accept && !op_legal;
      done_q   <= (state_nxt == S_ISSUE) ? 1'b0 : tp_done;
      if (accept && op_legal) begin
        op_q    <= cmd_op;
        rows_q  <= (cmd_op == OP_DOT) ? '0 : cmd_rows_m1;
        cols_q  <= (cmd_op == OP_DOT) ? '0 : cmd_cols_m1;
        i_q     <= '0;
        j_q     <= '0;
        count_q <= '0;
      end else if (!abort) begin
        if (complete) count_q <= count_q + (2*TILE_W+1)'(1);
        if (state == S_NEXT) begin
          if (j_q < cols_q) begin
            j_q <= j_q + TILE_W'(1);
          end else if (i_q < rows_q) begin
            j_q <= '0;
            i_q <= i_q + TILE_W'(1);
          end
        end
      end
    end
  end

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign tp_start   = (state == S_ISSUE) && !abort;
  assign sched_done = (state == S_FINISH) && !abort;
  assign tp_tile_i  = i_q;
  assign tp_tile_j  = j_q;
  assign tp_op_code = op_q;
  assign tiles_done = count_q;
  assign err_op     = err_op_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: command vector table, start-order scoreboard and corner-case sequences.
module tb_tile_scheduler;

  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [TW-1:0] cmd_rows_m1 = '0;
  logic [TW-1:0] cmd_cols_m1 = '0;
  logic          abort = 1'b0;
  logic          tp_start;
  logic [TW-1:0] tp_tile_i, tp_tile_j;
  logic [2:0]    tp_op_code;
  logic          tp_done;
  logic          busy, sched_done, err_op, err_timeout;
  logic [2*TW:0] tiles_done;

  tile_scheduler #(.TILE_W(TW), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rows_m1(cmd_rows_m1), .cmd_cols_m1(cmd_cols_m1), .abort(abort), .tp_start(tp_start),
    .tp_tile_i(tp_tile_i), .tp_tile_j(tp_tile_j), .tp_op_code(tp_op_code), .tp_done(tp_done),
    .busy(busy), .sched_done(sched_done), .tiles_done(tiles_done), .err_op(err_op),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // tile_processor model: done drops one cycle after start, rises lat cycles after start
  int   lat = 20;
  bit   resp_en = 1'b1;
  bit   manual = 1'b0;
  logic man_done = 1'b0;
  logic resp_done = 1'b0;
  int   resp_cnt = 0;
  bit   resp_pend = 1'b0;

  assign tp_done = manual ? man_done : resp_done;

  always @(negedge clk) begin
    if (tp_start) begin
      resp_cnt  = lat;
      resp_pend = 1'b1;
    end else if (resp_pend) begin
      resp_cnt--;
      if (resp_cnt == lat - 1) resp_done = 1'b0;
      if (resp_cnt == 0) begin
        resp_done = resp_en;
        resp_pend = 1'b0;
      end
    end
  end

  typedef struct {
    logic [2:0] i;
    logic [2:0] j;
    logic [2:0] op;
  } tile_t;

  tile_t exp_q[$];
  int    start_cnt = 0;
  int    sched_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tp_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: got start at (%0d,%0d), want none", tp_tile_i, tp_tile_j);
        end else begin
          tile_t e;
          e = exp_q.pop_front();
          check("start_i", tp_tile_i, e.i);
          check("start_j", tp_tile_j, e.j);
          check("start_op", tp_op_code, e.op);
        end
      end
      if (sched_done) sched_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command for a single cycle; returns at edge+1 of the cycle after the handshake.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] r, input logic [2:0] c);
    int nr, nc;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_rows_m1 = r;
    cmd_cols_m1 = c;
    if (op >= 3'd1 && op <= 3'd4) begin
      nr = (op == 3'd4) ? 1 : int'(r) + 1;
      nc = (op == 3'd4) ? 1 : int'(c) + 1;
      for (int ii = 0; ii < nr; ii++)
        for (int jj = 0; jj < nc; jj++)
          exp_q.push_back('{i: 3'(ii), j: 3'(jj), op: op});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] rows;
    logic [2:0] cols;
    bit         err;
    int         tiles;
    logic [2:0] fi;
    logic [2:0] fj;
    logic [2:0] fop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int s0, d0, k;

    vecs[0] = '{3'd1, 3'd1, 3'd1, 1'b0, 4, 3'd1, 3'd1, 3'd1};
    vecs[1] = '{3'd4, 3'd7, 3'd7, 1'b0, 1, 3'd0, 3'd0, 3'd4};
    vecs[2] = '{3'd0, 3'd3, 3'd3, 1'b1, 1, 3'd0, 3'd0, 3'd4};
    vecs[3] = '{3'd6, 3'd2, 3'd2, 1'b1, 1, 3'd0, 3'd0, 3'd4};
    vecs[4] = '{3'd2, 3'd0, 3'd2, 1'b0, 3, 3'd0, 3'd2, 3'd2};
    vecs[5] = '{3'd3, 3'd2, 3'd0, 1'b0, 3, 3'd2, 3'd0, 3'd3};
    vecs[6] = '{3'd7, 3'd0, 3'd0, 1'b1, 3, 3'd2, 3'd0, 3'd3};
    vecs[7] = '{3'd5, 3'd1, 3'd1, 1'b1, 3, 3'd2, 3'd0, 3'd3};
    vecs[8] = '{3'd2, 3'd0, 3'd0, 1'b0, 1, 3'd0, 3'd0, 3'd2};

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tp_start", tp_start, 0);
    check("rst_tiles_done", tiles_done, 0);
    check("rst_op_code", tp_op_code, 0);
    check("rst_err", {err_op, err_timeout, sched_done}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Command table
    foreach (vecs[v]) begin
      s0 = start_cnt;
      d0 = sched_cnt;
      send_cmd(vecs[v].op, vecs[v].rows, vecs[v].cols);
      if (vecs[v].err) begin
        check("err_op_pulse", err_op, 1);
        check("err_no_start", tp_start, 0);
        check("err_busy", busy, 0);
        check("err_cmd_ready", cmd_ready, 1);
        tick();
        check("err_op_one_cycle", err_op, 0);
      end else begin
        check("start_latency", tp_start, 1);
        check("busy_active", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
        wait_idle(2000, "cmd_complete");
      end
      check("vec_tiles_done", tiles_done, vecs[v].tiles);
      check("vec_final_i", tp_tile_i, vecs[v].fi);
      check("vec_final_j", tp_tile_j, vecs[v].fj);
      check("vec_final_op", tp_op_code, vecs[v].fop);
      check("vec_start_count", start_cnt - s0, vecs[v].err ? 0 : vecs[v].tiles);
      check("vec_sched_done_count", sched_cnt - d0, vecs[v].err ? 0 : 1);
      check("vec_cmd_ready_after", cmd_ready, 1);
      tick();
    end

    // Cycle-exact timing, 1x2 grid, latency 5, done still high from previous command
    lat = 5;
    send_cmd(3'd1, 3'd0, 3'd1);
    check("timing_start0", tp_start, 1);
    for (int c = 1; c <= 15; c++) begin
      tick();
      check("timing_start", tp_start, (c == 7) ? 1 : 0);
      check("timing_sched_done", sched_done, (c == 14) ? 1 : 0);
      check("timing_busy", busy, (c <= 14) ? 1 : 0);
    end
    check("timing_tiles_done", tiles_done, 2);
    lat = 20;

    // Held-over done level must not complete the first tile
    manual   = 1'b1;
    man_done = 1'b1;
    tick();
    d0 = sched_cnt;
    send_cmd(3'd2, 3'd0, 3'd0);
    for (int c = 0; c < 10; c++) tick();
    check("held_no_advance", tiles_done, 0);
    check("held_busy", busy, 1);
    man_done = 1'b0;
    tick();
    check("held_still_waiting", tiles_done, 0);
    man_done = 1'b1;
    tick();
    check("held_edge_completes", tiles_done, 1);
    wait_idle(20, "held_finish");
    check("held_sched_done", sched_cnt - d0, 1);
    manual = 1'b0;
    tick();

    // Abort in WAIT of tile 3
    s0 = start_cnt;
    d0 = sched_cnt;
    send_cmd(3'd1, 3'd1, 3'd1);
    k = 0;
    while (start_cnt < s0 + 3 && k < 500) begin
      tick();
      k++;
    end
    check("abort_reached_tile3", start_cnt - s0, 3);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_tiles_done", tiles_done, 2);
    for (int c = 0; c < 30; c++) tick();
    check("abort_no_sched_done", sched_cnt - d0, 0);
    check("abort_no_more_start", start_cnt - s0, 3);
    exp_q.delete();

    // Abort during ISSUE masks the start pulse
    s0 = start_cnt;
    send_cmd(3'd3, 3'd1, 3'd1);
    abort = 1'b1;
    #1;
    check("abort_issue_no_start", tp_start, 0);
    tick();
    abort = 1'b0;
    check("abort_issue_idle", busy, 0);
    check("abort_issue_tiles", tiles_done, 0);
    tick();
    check("abort_issue_start_count", start_cnt - s0, 0);
    exp_q.delete();

    // Stalled tp_done
    resp_en = 1'b0;
    d0 = sched_cnt;
    send_cmd(3'd2, 3'd0, 3'd0);
`ifdef TILE_SCHED_TIMEOUT_EN
    for (int c = 1; c <= 1025; c++) begin
      tick();
      if (c == 1024) begin
        check("wd_busy_before", busy, 1);
        check("wd_err_before", err_timeout, 0);
      end
    end
    check("wd_idle", busy, 0);
    check("wd_err_timeout", err_timeout, 1);
    check("wd_no_sched_done", sched_cnt - d0, 0);
    check("wd_tiles_done", tiles_done, 0);
`else
    for (int c = 0; c < 1100; c++) tick();
    check("stall_busy", busy, 1);
    check("stall_err_timeout", err_timeout, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("stall_abort_idle", busy, 0);
`endif
    resp_en = 1'b1;
    tick();
    send_cmd(3'd1, 3'd0, 3'd0);
    check("wd_cleared_by_cmd", err_timeout, 0);
    wait_idle(100, "after_stall_complete");
    check("after_stall_tiles", tiles_done, 1);
    tick();

    // Asynchronous reset in the ISSUE cycle of tile 2
    send_cmd(3'd3, 3'd0, 3'd1);
    k = 0;
    while (!(tp_start && tp_tile_j == 3'd1) && k < 100) begin
      tick();
      k++;
    end
    check("rst_mid_reached", tp_start, 1);
    check("rst_mid_tiles_before", tiles_done, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tp_start", tp_start, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_tiles", tiles_done, 0);
    check("rst_mid_idx", {tp_tile_i, tp_tile_j}, 0);
    check("rst_mid_op", tp_op_code, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("rst_mid_stays_idle", busy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
